// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and feeds the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles delivery counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic [31:0] fetch_pc_out,
  output logic [31:0] fetch_inst
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [XLEN-1:0]   out_inst_q, out_inst_d;
  logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
  logic [XLEN-1:0]   hold_inst_q, hold_inst_d;
  logic              fetched_inc_c;
  logic              bubble_inc_c;
  logic [XLEN-1:0]   redir_pc_c;
  logic [XLEN-1:0]   pc_inc_c;

  assign redir_pc_c = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc_c   = pc_q + XLEN'(4);

  // Next-state and next-output logic; redirect outranks stall and ack in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_d         = req_q;
    addr_d        = addr_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    hold_pc_d     = hold_pc_q;
    hold_inst_d   = hold_inst_q;
    fetched_inc_c = 1'b0;
    bubble_inc_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d      = REQ;
        req_d        = 1'b1;
        addr_d       = pc_q;
        bubble_inc_c = 1'b1;
        if (redirect_valid) begin
          pc_d       = redir_pc_c;
          addr_d     = redir_pc_c;
          out_pc_d   = redir_pc_c;
          out_inst_d = NOP_INST;
        end
      end

      REQ: begin
        if (redirect_valid) begin
          pc_d         = redir_pc_c;
          out_pc_d     = redir_pc_c;
          out_inst_d   = NOP_INST;
          bubble_inc_c = 1'b1;
          if (imem_ack) addr_d = redir_pc_c;
          else          state_d = KILL;
        end else if (imem_ack && !stall) begin
          out_pc_d      = pc_q;
          out_inst_d    = imem_rdata;
          pc_d          = pc_inc_c;
          addr_d        = pc_inc_c;
          fetched_inc_c = 1'b1;
        end else if (imem_ack) begin
          hold_pc_d   = pc_q;
          hold_inst_d = imem_rdata;
          pc_d        = pc_inc_c;
          req_d       = 1'b0;
          state_d     = HOLD;
        end else if (!stall) begin
          out_pc_d     = pc_q;
          out_inst_d   = NOP_INST;
          bubble_inc_c = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d         = redir_pc_c;
          out_pc_d     = redir_pc_c;
          out_inst_d   = NOP_INST;
          req_d        = 1'b1;
          addr_d       = redir_pc_c;
          state_d      = REQ;
          bubble_inc_c = 1'b1;
        end else if (!stall) begin
          out_pc_d      = hold_pc_q;
          out_inst_d    = hold_inst_q;
          req_d         = 1'b1;
          addr_d        = pc_q;
          state_d       = REQ;
          fetched_inc_c = 1'b1;
        end
      end

      KILL: begin
        // Old request stays on the bus until acked; its data is dropped.
        out_inst_d   = NOP_INST;
        bubble_inc_c = 1'b1;
        if (redirect_valid) begin
          pc_d     = redir_pc_c;
          out_pc_d = redir_pc_c;
        end else if (imem_ack) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      out_pc_q    <= '0;
      out_inst_q  <= NOP_INST;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign fetch_pc_out = out_pc_q;
  assign fetch_inst   = out_inst_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
  logic [XLEN-1:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + XLEN'(fetched_inc_c);
    perf_bubbles_d = perf_bubbles_q + XLEN'(bubble_inc_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_perf_c;
  assign unused_perf_c = fetched_inc_c ^ bubble_inc_c;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit: per-cycle input vectors with expected
// request/address before the edge and expected IF/ID outputs after it.
module tb_if_fetch_unit;

  localparam logic [31:0] W   = 32'h0010_0093;
  localparam logic [31:0] N   = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] fetch_pc_out;
  logic [31:0] fetch_inst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .fetch_pc_out   (fetch_pc_out),
    .fetch_inst     (fetch_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                     input logic a, input logic [31:0] rd, input logic er, input logic [31:0] ea,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v = '{r, s, rv, rpc, a, rd, er, ea, ep, ei};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic a, input logic [31:0] rd);
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = a;
    imem_rdata     = rd;
  endtask

  initial begin
    //   rst stall rv rpc           ack rdata  req addr          pc            inst
    add(1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);  // in reset
    add(0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);  // IDLE
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h0,         32'h0,         W);  // zero-wait stream
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h4,         32'h4,         W);
    add(0, 1, 0, 32'h0,         1, W,      1, 32'h8,         32'h4,         W);  // ack+stall at pc 8
    add(0, 1, 0, 32'h0,         0, 32'h0,  0, 32'h8,         32'h4,         W);
    add(0, 1, 0, 32'h0,         0, 32'h0,  0, 32'h8,         32'h4,         W);
    add(0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h8,         32'h8,         W);  // release holds
    add(0, 0, 0, 32'h0,         1, W,      1, 32'hC,         32'hC,         W);
    add(0, 0, 1, 32'hFFFF_FFFC, 1, W,      1, 32'h10,        32'hFFFF_FFFC, N);  // redirect with ack
    add(0, 0, 0, 32'h0,         1, W,      1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, W);
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h0,         32'h0,         W);  // wrapped pc
    add(0, 0, 0, 32'h0,         0, 32'h0,  1, 32'h4,         32'h4,         N);  // bubble at 4
    add(0, 0, 1, 32'h103,       0, 32'h0,  1, 32'h4,         32'h100,       N);  // redirect -> KILL
    add(0, 0, 0, 32'h0,         0, 32'h0,  1, 32'h4,         32'h100,       N);
    add(0, 0, 0, 32'h0,         1, BAD,    1, 32'h4,         32'h100,       N);  // late ack discarded
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h100,       32'h100,       W);
    add(0, 0, 0, 32'h0,         0, 32'h0,  1, 32'h104,       32'h104,       N);
    add(1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);  // reset mid-request
    add(0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);
    add(0, 0, 0, 32'h0,         0, 32'h0,  1, 32'h0,         32'h0,         N);  // 2-cycle ack delay
    add(0, 0, 0, 32'h0,         0, 32'h0,  1, 32'h0,         32'h0,         N);
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h0,         32'h0,         W);
    add(0, 1, 0, 32'h0,         1, W,      1, 32'h4,         32'h0,         W);  // into HOLD
    add(1, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);  // reset mid-HOLD
    add(0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0,         32'h0,         N);
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h0,         32'h0,         W);  // restart at 0
    add(0, 1, 0, 32'h0,         0, 32'h0,  1, 32'h4,         32'h0,         W);  // stall, no ack
    add(0, 0, 0, 32'h0,         1, W,      1, 32'h4,         32'h4,         W);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      #1;
      chk("req_pre", i, 32'(imem_req), 32'(vecs[i].e_req));
      chk("addr_pre", i, imem_addr, vecs[i].e_addr);
      if (vecs[i].rst) begin
        chk("pc_in_reset", i, fetch_pc_out, 32'h0);
        chk("inst_in_reset", i, fetch_inst, N);
      end
      @(posedge clk);
      #1;
      chk("pc_post", i, fetch_pc_out, vecs[i].e_pc);
      chk("inst_post", i, fetch_inst, vecs[i].e_inst);
    end

    // KILL held under stall: outputs stay NOP, stale ack releases KILL.
    @(negedge clk);
    drive(0, 0, 1, 32'h202, 0, 32'h0);
    @(posedge clk); #1;
    chk("kill_pc", 100, fetch_pc_out, 32'h200);
    chk("kill_inst", 100, fetch_inst, N);
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;
    chk("kill_stall_inst", 101, fetch_inst, N);
    chk("kill_stall_addr", 101, imem_addr, 32'h8);
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 1, BAD);
    @(posedge clk); #1;
    chk("kill_ack_inst", 102, fetch_inst, N);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    begin
      int budget;
      budget = 10;
      while (!(imem_req && imem_addr == 32'h200) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("redirect_req_seen", 103, 32'(budget > 0), 32'h1);
    end
    drive(0, 0, 0, 32'h0, 1, W);
    @(posedge clk); #1;
    chk("redirect_first_pc", 104, fetch_pc_out, 32'h200);
    chk("redirect_first_inst", 104, fetch_inst, W);
    chk("redirect_next_addr", 104, imem_addr, 32'h204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC, fetches instructions from instruction memory over a req/ack handshake, and drives the pc/inst pair into the IF/ID pipeline register each cycle.
- Handles downstream stall, branch/jump redirect from EX, and bubble (NOP 32'h00000013) insertion while waiting on memory or after a flush.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold the fetch outputs.
- redirect_valid  input  1  EX requests a PC change this cycle.
- redirect_pc  input  32  target PC; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; word aligned.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word; valid only when imem_ack=1.
- fetch_pc_out  output  32  PC of the delivered instruction, to IF/ID pc input.
- fetch_inst  output  32  delivered instruction or NOP_INST, to IF/ID inst input.

Behaviour:
- Reset (async):
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - fetch_pc_out=32'h0, fetch_inst=NOP_INST.
  - Reset asserted mid-request abandons the request immediately; memory must tolerate req dropping.
- Registered outputs: fetch_pc_out and fetch_inst update only at posedge.
- States:
  - IDLE: one cycle after reset release, then REQ. Outputs NOP.
  - REQ: imem_req=1, imem_addr=pc. req and addr are held stable until ack.
    - ack & !stall: deliver inst (fetch_pc_out<=pc, fetch_inst<=rdata), pc<=pc+4, stay in REQ. The next request issues in the following cycle, so back-to-back throughput is 1 inst/cycle with a zero-wait memory.
    - ack & stall: capture {pc, rdata} into the hold buffer, pc<=pc+4, go to HOLD. Outputs are unchanged.
    - !ack & !stall: deliver a bubble (fetch_inst<=NOP_INST, fetch_pc_out<=pc).
    - !ack & stall: outputs are unchanged.
  - HOLD: imem_req=0.
    - When stall drops: deliver the held {pc, inst}, go to REQ.
    - While stall=1: outputs are unchanged.
  - KILL: request outstanding while a redirect occurred. imem_req=1 with the old address.
    - On ack: discard rdata, go to REQ (new pc already loaded).
    - Outputs NOP while in KILL, regardless of stall.
- Redirect has priority over stall and ack:
  - Always: pc<=redirect_pc & ~3; fetch_inst<=NOP_INST; fetch_pc_out<=redirect_pc & ~3.
  - In REQ without ack: go to KILL.
  - In REQ with ack: discard rdata, stay in REQ.
  - In HOLD: drop the held entry, go to REQ.
  - In KILL: update pc, stay in KILL.
  - In IDLE: update pc only.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
- The stall input is level-sensitive with no latency; it is sampled at the same edge as ack.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both reset to 0.
  - perf_fetched increments on each real instruction delivered to the outputs.
  - perf_bubbles increments on each NOP delivered that is not caused by stall.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning word 32'h00100093 at every address:
  - Required: cycle 1 imem_req=1, addr=0.
  - Then fetch_pc_out=0,4,8 on consecutive cycles with fetch_inst=32'h00100093.
- Memory ack delayed by 2 cycles at address 0:
  - Required: fetch_inst=32'h00000013 for 2 cycles, then the real instruction with fetch_pc_out=0.
  - imem_addr is held at 0 throughout.
- stall=1 asserted in the same cycle as ack at pc=8, held 3 cycles:
  - Required: outputs frozen and imem_req=0 during the stall.
  - On release, fetch_pc_out=8 is delivered; the next request addr is 12.
- redirect_valid=1 with redirect_pc=32'h00000103 while waiting on ack at addr 4:
  - Required: NOP output; rdata at the late ack is discarded.
  - Next imem_addr=32'h00000100.
- Redirect to 32'hFFFFFFFC with zero-wait memory:
  - Required: delivered pcs FFFFFFFC, then 00000000.
- Assert rst mid-request and mid-HOLD:
  - Required: immediate imem_req=0, fetch_inst=32'h00000013, fetch_pc_out=0.
  - Fetch restarts at RESET_PC.
